// File: rtl/adrd_parse.sv
// ADC read-frame parser: watches one SPI read per trigger, validates the returned
// frame (parity, format, range), publishes good codes and tracks sticky errors.
module adrd_parse #(
  parameter logic [3:0]  EXP_RANGE = 4'h0,
  parameter logic [15:0] TMO_CNT   = 16'd2500
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        rd_trig,
  input  logic        rd_done,
  input  logic [31:0] rd_data,
  input  logic        err_clr,
  output logic [15:0] ad_data,
  output logic        ad_vld,
  output logic [1:0]  ad_alarm,
  output logic        ad_err,
  output logic [2:0]  err_type,
  output logic [7:0]  err_cnt,
  output logic [1:0]  state_dbg
);

  // Handshake: rd_trig opens a read window; the first rd_done inside the
  // window delivers the frame. Pulses outside that window are ignored.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wdog, wdog_nxt;
  logic [31:0] frame, frame_nxt;
  logic        tmo_evt;
  logic        chk_evt;
  logic        fmt_bad;
  logic        rng_bad;
  logic        good_evt;
  logic [2:0]  err_bits;
  logic        err_evt;
  logic [2:0]  type_base;
  logic [7:0]  cnt_base;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state <= S_IDLE;
      wdog  <= 16'h0000;
      frame <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      frame <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    frame_nxt = frame;
    tmo_evt   = 1'b0;
    chk_evt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_trig) begin
          state_nxt = S_WAIT;
          wdog_nxt  = 16'h0000;
        end
      end
      S_WAIT: begin
        wdog_nxt = wdog + 16'd1;
        // rd_done takes priority over an expiring watchdog in the same cycle
        if (rd_done) begin
          state_nxt = S_CHECK;
          frame_nxt = rd_data;
        end else if (wdog == TMO_CNT - 16'd1) begin
          state_nxt = S_IDLE;
          tmo_evt   = 1'b1;
        end
      end
      S_CHECK: begin
        state_nxt = S_IDLE;
        chk_evt   = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A parity/format fault masks the range check so only one error bit is set.
  assign fmt_bad  = (^frame[31:16] ^ frame[9]) | (|frame[8:0]);
  assign rng_bad  = (frame[15:12] != EXP_RANGE) & ~fmt_bad;
  assign good_evt = chk_evt & ~fmt_bad & ~rng_bad;
  assign err_bits = {tmo_evt, chk_evt & rng_bad, chk_evt & fmt_bad};
  assign err_evt  = |err_bits;

  // Clear first, then apply any coincident error event on top.
  assign type_base = err_clr ? 3'b000 : err_type;
  assign cnt_base  = err_clr ? 8'h00 : err_cnt;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      ad_data  <= 16'h0000;
      ad_alarm <= 2'b00;
      ad_vld   <= 1'b0;
      ad_err   <= 1'b0;
      err_type <= 3'b000;
      err_cnt  <= 8'h00;
    end else begin
      ad_vld   <= good_evt;
      ad_err   <= err_evt;
      err_type <= type_base | err_bits;
      err_cnt  <= (err_evt && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
      if (good_evt) begin
        ad_data  <= frame[31:16];
        ad_alarm <= frame[11:10];
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_adrd_parse.sv
// Scoreboard bench for adrd_parse: drivers push expected output events, a
// negedge monitor pops and compares each ad_vld / ad_err pulse.
module tb_adrd_parse;

  localparam int TMO = 48;
  localparam int W   = 62;

  logic        clk_sys;
  logic        rst_sys_n;
  logic        rd_trig;
  logic        rd_done;
  logic [31:0] rd_data;
  logic        err_clr;
  logic [15:0] ad_data;
  logic        ad_vld;
  logic [1:0]  ad_alarm;
  logic        ad_err;
  logic [2:0]  err_type;
  logic [7:0]  err_cnt;
  logic [1:0]  state_dbg;

  adrd_parse #(.EXP_RANGE(4'h0), .TMO_CNT(16'(TMO))) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .rd_trig   (rd_trig),
    .rd_done   (rd_done),
    .rd_data   (rd_data),
    .err_clr   (err_clr),
    .ad_data   (ad_data),
    .ad_vld    (ad_vld),
    .ad_alarm  (ad_alarm),
    .ad_err    (ad_err),
    .err_type  (err_type),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [15:0]  m_data  = 16'h0000;
  logic [1:0]   m_alarm = 2'b00;
  logic [2:0]   m_type  = 3'b000;
  logic [7:0]   m_cnt   = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Event packing: {cycle, is_err, data, alarm, type, cnt}
  task automatic push_exp(input int at, input bit is_err, input logic [2:0] bits,
                          input bit clr, input logic [31:0] d);
    if (clr) begin
      m_type = 3'b000;
      m_cnt  = 8'h00;
    end
    if (is_err) begin
      m_type = m_type | bits;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end else begin
      m_data  = d[31:16];
      m_alarm = d[11:10];
    end
    exp_q.push_back({32'(at), is_err, m_data, m_alarm, m_type, m_cnt});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_sys) begin
    logic [W-1:0] e;
    if (rst_sys_n) begin
      if (ad_vld && ad_err) chk("vld_err_excl", 32'd1, 32'd0);
      if (ad_vld || ad_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, ad_err, ad_vld}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("evt_cycle", 32'(cyc),        e[61:30]);
          chk("evt_kind",  {31'd0, ad_err}, {31'd0, e[29]});
          chk("ad_data",   {16'd0, ad_data}, {16'd0, e[28:13]});
          chk("ad_alarm",  {30'd0, ad_alarm}, {30'd0, e[12:11]});
          chk("err_type",  {29'd0, err_type}, {29'd0, e[10:8]});
          chk("err_cnt",   {24'd0, err_cnt}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // kind: 0 good, 1 parity/format, 2 range (hand-classified per vector)
  task automatic run_frame(input int d, input logic [31:0] data, input int kind,
                           input bit trig_mid, input bit done_twice);
    int t;
    @(negedge clk_sys);
    rd_trig = 1'b1;
    t = cyc;
    for (int k = 1; k <= d; k++) begin
      @(negedge clk_sys);
      rd_trig = (trig_mid && k == d / 2 && k < d);
      rd_done = (k == d);
      rd_data = (k == d) ? data : 32'hDEAD_BEEF;
    end
    if (kind == 0) push_exp(t + d + 2, 1'b0, 3'b000, 1'b0, data);
    else push_exp(t + d + 2, 1'b1, (kind == 1) ? 3'b001 : 3'b010, 1'b0, data);
    @(negedge clk_sys);
    rd_trig = trig_mid;
    rd_done = done_twice;
    rd_data = 32'h5678_0200;
    @(negedge clk_sys);
    rd_trig = 1'b0;
    rd_done = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic run_tmo(input bit clr_at_end, input bit late_done);
    int t;
    @(negedge clk_sys);
    rd_trig = 1'b1;
    t = cyc;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk_sys);
      rd_trig = 1'b0;
      err_clr = clr_at_end && (k == TMO);
    end
    push_exp(t + TMO + 1, 1'b1, 3'b100, clr_at_end, 32'h0);
    @(negedge clk_sys);
    err_clr = 1'b0;
    rd_done = late_done;
    rd_data = 32'h1234_0200;
    @(negedge clk_sys);
    rd_done = 1'b0;
  endtask

  task automatic do_clr;
    @(negedge clk_sys);
    err_clr = 1'b1;
    @(negedge clk_sys);
    err_clr = 1'b0;
    m_type = 3'b000;
    m_cnt  = 8'h00;
    chk("clr_type", {29'd0, err_type}, 32'd0);
    chk("clr_cnt",  {24'd0, err_cnt},  32'd0);
  endtask

  task automatic chk_levels(input string tag);
    chk({tag, "_data"},  {16'd0, ad_data},  {16'd0, m_data});
    chk({tag, "_alarm"}, {30'd0, ad_alarm}, {30'd0, m_alarm});
    chk({tag, "_type"},  {29'd0, err_type}, {29'd0, m_type});
    chk({tag, "_cnt"},   {24'd0, err_cnt},  {24'd0, m_cnt});
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          dly;
    logic [31:0] data;
    int          kind;
    bit          trig_mid;
    bit          done_twice;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{40,  32'h1234_0200, 0, 1'b0, 1'b0};
    vecs[1] = '{40,  32'h1234_0000, 1, 1'b0, 1'b0};
    vecs[2] = '{10,  32'h1234_1200, 2, 1'b1, 1'b0};
    vecs[3] = '{1,   32'h1234_0201, 1, 1'b0, 1'b1};
    vecs[4] = '{7,   32'hABCD_0C00, 0, 1'b1, 1'b1};
    vecs[5] = '{3,   32'hABCD_1E00, 1, 1'b0, 1'b0};
    vecs[6] = '{20,  32'h0001_0A00, 0, 1'b0, 1'b1};
    vecs[7] = '{TMO, 32'h0000_0000, 0, 1'b0, 1'b0};

    rst_sys_n = 1'b0;
    rd_trig   = 1'b0;
    rd_done   = 1'b0;
    rd_data   = 32'h0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk_levels("rst");
    chk("rst_vld",   {31'd0, ad_vld},    32'd0);
    chk("rst_err",   {31'd0, ad_err},    32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_sys_n = 1'b1;

    // rd_done before any rd_trig must be ignored
    @(negedge clk_sys);
    rd_done = 1'b1;
    rd_data = 32'h1234_0200;
    @(negedge clk_sys);
    rd_done = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk_levels("stray");

    foreach (vecs[i]) begin
      run_frame(vecs[i].dly, vecs[i].data, vecs[i].kind, vecs[i].trig_mid, vecs[i].done_twice);
      chk_levels("vec");
    end

    do_clr();
    run_tmo(1'b0, 1'b0);
    chk_levels("tmo");
    run_tmo(1'b0, 1'b1);
    chk_levels("tmo_late");

    for (int i = 0; i < 300; i++) run_tmo(1'b0, 1'b0);
    repeat (2) @(negedge clk_sys);
    chk("sat_cnt", {24'd0, err_cnt}, 32'h0000_00FF);
    run_tmo(1'b1, 1'b0);
    repeat (2) @(negedge clk_sys);
    chk("clr_evt_cnt",  {24'd0, err_cnt},  32'd1);
    chk("clr_evt_type", {29'd0, err_type}, 32'd4);

    // Reset during CHECK: abort, no pulse afterwards
    run_frame(5, 32'hABCD_0C00, 0, 1'b0, 1'b0);
    @(negedge clk_sys);
    rd_trig = 1'b1;
    @(negedge clk_sys);
    rd_trig = 1'b0;
    repeat (4) @(negedge clk_sys);
    rd_done = 1'b1;
    rd_data = 32'h4321_0000;
    @(negedge clk_sys);
    rd_done   = 1'b0;
    rst_sys_n = 1'b0;
    #1;
    m_data  = 16'h0000;
    m_alarm = 2'b00;
    m_type  = 3'b000;
    m_cnt   = 8'h00;
    chk_levels("mid_rst");
    chk("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    rd_done = 1'b1;
    rd_data = 32'h1234_0200;
    @(negedge clk_sys);
    rd_done = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk_levels("post_rst");

    run_frame(12, 32'h0001_0A00, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk_sys);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
